// File: rtl/alu_share_arb_pkg.sv
// rtl/alu_share_arb_pkg.sv - shared constants and types for the ALU share arbiter
package alu_share_arb_pkg;

    localparam int ARB_NPORTS  = 2;
    localparam int ALU_ARB_OPW = 6;

    // All-ones opcode sits outside every ALUOP code, so the ALU falls into its default branch
    localparam logic [ALU_ARB_OPW-1:0] ALU_ARB_NOP = 6'h3F;

    typedef enum logic {
        ARB_PORT_EX  = 1'b0,
        ARB_PORT_AUX = 1'b1
    } arb_port_e;

endpackage

// File: rtl/alu_share_arb_if.sv
// rtl/alu_share_arb_if.sv - requester-side request/response bundle for both arbiter ports
interface alu_share_arb_if
    import alu_share_arb_pkg::*;
#(
    parameter int DW  = 32,
    parameter int OPW = 6
) ();

    logic [ARB_NPORTS-1:0]          req_valid;
    logic [ARB_NPORTS-1:0]          req_ready;
    logic [ARB_NPORTS-1:0][OPW-1:0] req_op;
    logic [ARB_NPORTS-1:0][DW-1:0]  req_src0;
    logic [ARB_NPORTS-1:0][DW-1:0]  req_src1;
    logic [ARB_NPORTS-1:0]          rsp_valid;
    logic [ARB_NPORTS-1:0]          rsp_ready;
    logic [ARB_NPORTS-1:0][DW-1:0]  rsp_result;
    logic [ARB_NPORTS-1:0]          rsp_zero;

    modport master (
        output req_valid, req_op, req_src0, req_src1, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero
    );

    modport slave (
        input  req_valid, req_op, req_src0, req_src1, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero
    );

endinterface

// File: rtl/alu_arb_rsp_buf.sv
// rtl/alu_arb_rsp_buf.sv - one-entry result/zero-flag buffer with valid/ready drain
module alu_arb_rsp_buf #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_result,
    input  logic          load_zero,
    input  logic          ready,
    output logic          valid,
    output logic [DW-1:0] result,
    output logic          zero
);

    // Capture the ALU result and hold it unchanged until the requester accepts it
    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= 1'b0;
            result <= '0;
            zero   <= 1'b0;
        end else if (load) begin
            valid  <= 1'b1;
            result <= load_result;
            zero   <= load_zero;
        end else if (valid && ready) begin
            valid  <= 1'b0;
            result <= '0;
            zero   <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - two-port arbiter sharing one registered ALU; ALU_ARB_RR_EN selects round-robin
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int DW  = 32,
    parameter int OPW = 6
) (
    input  logic              clk,
    input  logic              rst,
    alu_share_arb_if.slave    bus,
    output logic [OPW-1:0]    alu_op,
    output logic [DW-1:0]     alu_src0,
    output logic [DW-1:0]     alu_src1,
    input  logic [DW-1:0]     alu_result,
    input  logic              alu_zero
);

    logic [ARB_NPORTS-1:0] eligible;
    logic [ARB_NPORTS-1:0] req_ready;
    logic [ARB_NPORTS-1:0] rsp_valid;
    logic [ARB_NPORTS-1:0] capture;
    logic                  grant_any;
    arb_port_e             grant_id;
    logic                  inflight_valid;
    arb_port_e             inflight_id;
`ifdef ALU_ARB_RR_EN
    arb_port_e             rr_ptr;
`endif

    // A port may issue only with nothing in flight and an empty response buffer
    always_comb begin
        eligible = '0;
        if (!rst) begin
            eligible[0] = bus.req_valid[0] && !(inflight_valid && inflight_id == ARB_PORT_EX)
                          && !rsp_valid[0];
            eligible[1] = bus.req_valid[1] && !(inflight_valid && inflight_id == ARB_PORT_AUX)
                          && !rsp_valid[1];
        end
    end

    // Pick at most one winner and steer its opcode/operands straight to the ALU
    always_comb begin
        grant_any = |eligible;
        grant_id  = ARB_PORT_EX;
`ifdef ALU_ARB_RR_EN
        if (eligible[rr_ptr]) begin
            grant_id = rr_ptr;
        end else begin
            grant_id = arb_port_e'(~rr_ptr);
        end
`else
        if (!eligible[0]) begin
            grant_id = ARB_PORT_AUX;
        end
`endif
        req_ready = '0;
        alu_op    = OPW'(ALU_ARB_NOP);
        alu_src0  = '0;
        alu_src1  = '0;
        if (grant_any) begin
            req_ready[grant_id] = 1'b1;
            alu_op              = bus.req_op[grant_id];
            alu_src0            = bus.req_src0[grant_id];
            alu_src1            = bus.req_src1[grant_id];
        end
    end

    // In-flight tag mirrors the ALU's one-cycle latency so the result lands in the right buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_valid <= 1'b0;
            inflight_id    <= ARB_PORT_EX;
        end else begin
            inflight_valid <= grant_any;
            inflight_id    <= grant_id;
        end
    end

`ifdef ALU_ARB_RR_EN
    // After a grant the other port becomes preferred
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= ARB_PORT_EX;
        end else if (grant_any) begin
            rr_ptr <= arb_port_e'(~grant_id);
        end
    end
`endif

    assign capture[0] = inflight_valid && (inflight_id == ARB_PORT_EX);
    assign capture[1] = inflight_valid && (inflight_id == ARB_PORT_AUX);

    alu_arb_rsp_buf #(.DW(DW)) u_buf_ex (
        .clk         (clk),
        .rst         (rst),
        .load        (capture[0]),
        .load_result (alu_result),
        .load_zero   (alu_zero),
        .ready       (bus.rsp_ready[0]),
        .valid       (rsp_valid[0]),
        .result      (bus.rsp_result[0]),
        .zero        (bus.rsp_zero[0])
    );

    alu_arb_rsp_buf #(.DW(DW)) u_buf_aux (
        .clk         (clk),
        .rst         (rst),
        .load        (capture[1]),
        .load_result (alu_result),
        .load_zero   (alu_zero),
        .ready       (bus.rsp_ready[1]),
        .valid       (rsp_valid[1]),
        .result      (bus.rsp_result[1]),
        .zero        (bus.rsp_zero[1])
    );

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - directed and randomized self-checking bench for alu_share_arb
module tb_alu_share_arb;

    localparam int DW  = 32;
    localparam int OPW = 6;
    localparam logic [OPW-1:0] NOP     = 6'h3F;
    localparam logic [OPW-1:0] OP_ADD  = 6'd0;
    localparam logic [OPW-1:0] OP_SUB  = 6'd1;
    localparam logic [OPW-1:0] OP_AND  = 6'd2;
    localparam logic [OPW-1:0] OP_OR   = 6'd3;
    localparam logic [OPW-1:0] OP_XOR  = 6'd4;

    logic           clk = 1'b0;
    logic           rst;
    logic [OPW-1:0] alu_op;
    logic [DW-1:0]  alu_src0;
    logic [DW-1:0]  alu_src1;
    logic [DW-1:0]  alu_result;
    logic           alu_zero;

    int nvec = 0;
    int nerr = 0;

    alu_share_arb_if #(.DW(DW), .OPW(OPW)) bus ();

    alu_share_arb #(.DW(DW), .OPW(OPW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_op     (alu_op),
        .alu_src0   (alu_src0),
        .alu_src1   (alu_src1),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_f(input logic [OPW-1:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return '0;
        endcase
    endfunction

    // Registered ALU standing in for the real one
    always_ff @(posedge clk) begin
        alu_result <= alu_f(alu_op, alu_src0, alu_src1);
        alu_zero   <= (alu_f(alu_op, alu_src0, alu_src1) == '0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.req_valid = 2'b00;
        bus.req_op    = '0;
        bus.req_src0  = '0;
        bus.req_src1  = '0;
        bus.rsp_ready = 2'b11;
    endtask

    bit             pend [2];
    bit             outs [2];
    int             gcyc [2];
    logic [OPW-1:0] pop  [2];
    logic [DW-1:0]  pa   [2];
    logic [DW-1:0]  pb   [2];
    logic [DW-1:0]  eres [2];
    logic           ezero[2];
    bit             ptr;
    bit             e0, e1, w, any, erv;
    logic [1:0]     exp_ready;
    logic [1:0]     pat [3];

    initial begin
        rst = 1'b1;
        idle_inputs();

        // reset: two cycles held, outputs quiet
        next();
        #1;
        chk("reset_ready", bus.req_ready, 2'b00);
        chk("reset_rsp_valid", bus.rsp_valid, 2'b00);
        chk("reset_alu_op", alu_op, NOP);
        chk("reset_result", bus.rsp_result, '0);
        next();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("idle_ready", bus.req_ready, 2'b00);
            chk("idle_rsp_valid", bus.rsp_valid, 2'b00);
            chk("idle_alu_op", alu_op, NOP);
            chk("idle_src0", alu_src0, '0);
            next();
        end

        // single op on port 0: 5+7
        bus.req_valid = 2'b01;
        bus.req_op[0] = OP_ADD; bus.req_src0[0] = 32'd5; bus.req_src1[0] = 32'd7;
        #1;
        chk("single_ready", bus.req_ready, 2'b01);
        chk("single_alu_op", alu_op, OP_ADD);
        chk("single_src0", alu_src0, 32'd5);
        chk("single_src1", alu_src1, 32'd7);
        next();
        bus.req_valid = 2'b00;
        #1;
        chk("single_n1_rsp_valid", bus.rsp_valid, 2'b00);
        next();
        #1;
        chk("single_n2_rsp_valid", bus.rsp_valid, 2'b01);
        chk("single_result", bus.rsp_result[0], 32'd12);
        chk("single_zero", bus.rsp_zero[0], 1'b0);
        next();
        #1;
        chk("single_drained", bus.rsp_valid, 2'b00);
        next();

        // zero flag on port 1: 9-9
        bus.req_valid = 2'b10;
        bus.req_op[1] = OP_SUB; bus.req_src0[1] = 32'd9; bus.req_src1[1] = 32'd9;
        #1;
        chk("zero_ready", bus.req_ready, 2'b10);
        next();
        bus.req_valid = 2'b00;
        next();
        #1;
        chk("zero_rsp_valid", bus.rsp_valid, 2'b10);
        chk("zero_result", bus.rsp_result[1], 32'd0);
        chk("zero_flag", bus.rsp_zero[1], 1'b1);
        next();

        // contention: both ports continuously valid, immediate drain
        pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b00;
        bus.req_valid = 2'b11;
        bus.req_op[0] = OP_ADD; bus.req_src0[0] = 32'd1; bus.req_src1[0] = 32'd1;
        bus.req_op[1] = OP_XOR; bus.req_src0[1] = 32'd3; bus.req_src1[1] = 32'd5;
        for (int i = 0; i < 9; i++) begin
            #1;
            chk("contend_ready", bus.req_ready, pat[i % 3]);
            if (i % 3 == 2) begin
                chk("contend_rsp0", bus.rsp_valid, 2'b01);
                chk("contend_res0", bus.rsp_result[0], 32'd2);
            end
            if (i % 3 == 0 && i > 0) begin
                chk("contend_rsp1", bus.rsp_valid, 2'b10);
                chk("contend_res1", bus.rsp_result[1], 32'd6);
            end
            next();
        end
        idle_inputs();
        next(); next(); next();

        // backpressure on port 0
        bus.rsp_ready = 2'b10;
        bus.req_valid = 2'b01;
        bus.req_op[0] = OP_ADD; bus.req_src0[0] = 32'd1; bus.req_src1[0] = 32'd2;
        #1;
        chk("bp_first_ready", bus.req_ready, 2'b01);
        next();
        bus.req_src0[0] = 32'd100; bus.req_src1[0] = 32'd200;
        #1;
        chk("bp_inflight_ready", bus.req_ready, 2'b00);
        next();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_hold_ready", bus.req_ready, 2'b00);
            chk("bp_hold_valid", bus.rsp_valid, 2'b01);
            chk("bp_hold_result", bus.rsp_result[0], 32'd3);
            next();
        end
        bus.rsp_ready = 2'b11;
        #1;
        chk("bp_pulse_ready", bus.req_ready, 2'b00);
        next();
        bus.rsp_ready = 2'b10;
        #1;
        chk("bp_regrant", bus.req_ready, 2'b01);
        chk("bp_regrant_src0", alu_src0, 32'd100);
        next();
        bus.req_valid = 2'b00;
        next();
        bus.rsp_ready = 2'b11;
        #1;
        chk("bp_second_valid", bus.rsp_valid, 2'b01);
        chk("bp_second_result", bus.rsp_result[0], 32'd300);
        next();
        #1;
        chk("bp_second_drained", bus.rsp_valid, 2'b00);
        next();

        // reset while an op is in flight
        bus.req_valid = 2'b10;
        bus.req_op[1] = OP_SUB; bus.req_src0[1] = 32'd20; bus.req_src1[1] = 32'd5;
        #1;
        chk("rmid_grant", bus.req_ready, 2'b10);
        next();
        rst = 1'b1;
        #1;
        chk("rmid_rst_gate", bus.req_ready, 2'b00);
        next();
        rst = 1'b0;
        bus.req_valid = 2'b00;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rmid_no_rsp", bus.rsp_valid, 2'b00);
            next();
        end
        bus.req_valid = 2'b10;
        bus.req_op[1] = OP_ADD;
        #1;
        chk("rmid_regrant", bus.req_ready, 2'b10);
        next();
        bus.req_valid = 2'b00;
        next();
        #1;
        chk("rmid_rsp_valid", bus.rsp_valid, 2'b10);
        chk("rmid_result", bus.rsp_result[1], 32'd25);
        next();

        // randomized traffic against a transaction-level model
        rst = 1'b1;
        idle_inputs();
        next(); next();
        rst = 1'b0;
        ptr = 1'b0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; outs[p] = 1'b0; gcyc[p] = 0;
            pop[p] = '0; pa[p] = '0; pb[p] = '0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 1) == 1) begin
                    pend[p] = 1'b1;
                    pop[p]  = OPW'($urandom_range(0, 5));
                    pa[p]   = $urandom;
                    pb[p]   = ($urandom_range(0, 3) == 0) ? pa[p] : $urandom;
                end
                bus.req_valid[p]    = pend[p];
                bus.req_op[p]       = pop[p];
                bus.req_src0[p]     = pa[p];
                bus.req_src1[p]     = pb[p];
                bus.rsp_ready[p]    = ($urandom_range(0, 3) != 0);
            end
            #1;
            e0  = pend[0] && !outs[0];
            e1  = pend[1] && !outs[1];
            any = e0 || e1;
`ifdef ALU_ARB_RR_EN
            if (ptr ? e1 : e0) w = ptr;
            else w = !ptr;
`else
            w = e0 ? 1'b0 : 1'b1;
`endif
            exp_ready = any ? (w ? 2'b10 : 2'b01) : 2'b00;
            chk("rand_ready", bus.req_ready, exp_ready);
            if (any) begin
                chk("rand_alu_op", alu_op, pop[w]);
                chk("rand_src0", alu_src0, pa[w]);
                chk("rand_src1", alu_src1, pb[w]);
            end else begin
                chk("rand_nop", alu_op, NOP);
            end
            for (int p = 0; p < 2; p++) begin
                erv = outs[p] && (c >= gcyc[p] + 2);
                chk("rand_rsp_valid", bus.rsp_valid[p], erv);
                if (erv && bus.rsp_ready[p]) begin
                    chk("rand_result", bus.rsp_result[p], eres[p]);
                    chk("rand_zero", bus.rsp_zero[p], ezero[p]);
                    outs[p] = 1'b0;
                end
            end
            if (any) begin
                outs[w]  = 1'b1;
                gcyc[w]  = c;
                eres[w]  = alu_f(pop[w], pa[w], pb[w]);
                ezero[w] = (eres[w] == '0);
                pend[w]  = 1'b0;
                ptr      = !w;
            end
            next();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-port arbiter that time-shares the single registered ALU between two requesters: the pipeline EX stage (port 0) and the auxiliary compute/debug path (port 1). It accepts operations over valid/ready handshakes and drives the ALU's opcode and operand inputs. It tracks the one-cycle ALU latency and returns each result with its zero flag to the requester that issued it, through a one-entry response buffer per port.

## Interface
Parameters:
- DW, 32, operand/result width
- OPW, 6, ALU opcode width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  per-port request valid
- req_ready  out  2  per-port request accepted this cycle
- req_op  in  2×OPW  per-port ALUOP code
- req_src0 / req_src1  in  2×DW each  per-port operands
- rsp_valid  out  2  per-port result available
- rsp_ready  in  2  per-port result consumed
- rsp_result  out  2×DW  per-port buffered result
- rsp_zero  out  2  per-port buffered zero flag
- alu_op  out  OPW  to ALU opcode input
- alu_src0 / alu_src1  out  DW each  to ALU operands
- alu_result  in  DW  ALU registered result
- alu_zero  in  1  ALU zero flag

## Operation
- Per-port credit: a port is eligible when req_valid=1, it has no op in flight and its response buffer is empty. At most one outstanding op per port.
- Grant: at most one eligible port per cycle. Arbitration is combinational: req_ready[g]=1 for the winner only. alu_op/alu_src0/alu_src1 are muxed from the winner in the same cycle.
- No grant: alu_op = ALU_ARB_NOP and operands = 0. ALU_ARB_NOP is outside all ALUOP codes, so the ALU takes its default branch.
- In-flight register: {valid, id} set on the grant edge and cleared on the next edge.
- Capture: when in-flight is valid, alu_result and alu_zero are written into buffer[id] on that edge and rsp_valid[id] is set.
- Drain: rsp_valid[p] && rsp_ready[p] clears buffer p. Capture and drain for the same port cannot coincide, because the one-outstanding rule prevents it.
- Requester rule: a requester holds req_op/src stable with req_valid=1 until req_ready. The arbiter does not check this.
- States per port: IDLE → INFLIGHT (grant) → HELD (capture) → IDLE (drain).

## Timing
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_result=0, rsp_zero=0
  - alu_op=ALU_ARB_NOP, alu operands=0
  - in-flight invalid, RR pointer=0
- Reset mid-operation discards the in-flight op and both buffers.
- Latency:
  - Cycle N: grant.
  - End of cycle N: ALU samples.
  - Cycle N+1: alu_result is valid, and the arbiter captures it at the end of N+1.
  - Cycle N+2: rsp_valid is high.
  - Minimum per-port period is 3 cycles with immediate rsp_ready. Two ports interleaved give up to 2 ops per 3 cycles.
- A new grant to the other port is legal in the same cycle as a capture, so back-to-back ALU issue is supported.
- rsp_result/rsp_zero are stable while rsp_valid=1.

## Configuration
- ALU_ARB_RR_EN defined:
  - Round-robin arbitration. A 1-bit pointer names the preferred port.
  - After each grant the pointer moves to the non-granted port.
  - A tie goes to the pointer port.
- ALU_ARB_RR_EN undefined:
  - Fixed priority, port 0 (EX stage) always wins.
  - No pointer register.

## Structure
- Shared package/define file holds:
  - ALU_ARB_NOP
  - port count (2)
  - port id constants (ARB_PORT_EX=0, ARB_PORT_AUX=1)
- ALUOP codes come from the existing ALUOP definitions. They are not duplicated.
- Sub-module alu_arb_rsp_buf: one-entry result/zero buffer with valid/ready. It is instantiated twice.

## Test plan
- Reset then idle: hold rst 2 cycles, all req_valid=0 → req_ready=0, rsp_valid=0, alu_op=ALU_ARB_NOP for 5 cycles.
- Single op: port 0 issues ALUOP_ADD, 5+7 at cycle N → req_ready[0]=1 in N, rsp_valid[0]=1 in N+2 with rsp_result=12, rsp_zero=0.
- Zero flag: port 1 issues ALUOP_SUB, 9−9 → rsp_result=0, rsp_zero=1 on port 1. Port 0 sees no rsp_valid.
- Contention: both ports valid continuously, rsp_ready=1.
  - With ALU_ARB_RR_EN: grants alternate 0,1,0,1.
  - Without it: port 0 is granted every 3 cycles, and port 1 only in port 0's non-eligible cycles.
- Backpressure: port 0 rsp_ready=0 after one op → req_ready[0] stays 0 for a second valid request until rsp_ready pulses. The buffered result holds its value throughout.
- Reset mid-flight: assert rst in cycle N+1 after a grant → no rsp_valid appears afterward, and the next request is granted normally.
